// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Programmable tick generator. A down-counter reloads from the active reload
// value R, so the block emits a one-cycle `tick` every R+1 cycles while
// running. It can run periodically or as a one-shot.
//
// New configurations arrive through a valid/ready handshake into a shadow
// register. The shadow is promoted to the active register only at a period
// boundary, or immediately while idle. A period in progress is therefore
// never shortened or stretched.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active-low
//   cfg_valid    configuration offered
//   cfg_ready    shadow register free (handshake = cfg_valid && cfg_ready)
//   cfg_reload   reload value R; period = R+1 cycles
//   cfg_oneshot  1: stop after the next tick, 0: periodic
//   start        begin generating ticks (ignored while running)
//   stop         halt; overrides start
//   tick         one-cycle strobe
//   running      generator is in RUN
//   remaining    current down-counter value (0 while idle)
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_reload,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] r_act;
  logic             os_act;
  logic [WIDTH-1:0] r_shd;
  logic             os_shd;
  logic             pend;

  logic             cfg_hs;
  logic             cnt_zero;

  assign cfg_ready = !pend;
  assign cfg_hs    = cfg_valid && !pend;
  assign cnt_zero  = (cnt == '0);

  // The counter is forced to 0 whenever the generator leaves RUN, so the
  // counter can drive `remaining` directly.
  assign tick      = (state == RUN) && cnt_zero;
  assign running   = (state == RUN);
  assign remaining = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      r_act  <= '0;
      os_act <= 1'b0;
      r_shd  <= '0;
      os_shd <= 1'b0;
      pend   <= 1'b0;
    end else begin
      // Capture into the shadow first. A handshake can only occur with
      // pend low, so it never collides with a shadow promotion below. The
      // start-bypass path overrides pend again when it consumes the offer.
      if (cfg_hs) begin
        r_shd  <= cfg_reload;
        os_shd <= cfg_oneshot;
        pend   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            if (cfg_hs) begin
              // Bypass: the configuration offered this cycle is used at once.
              r_act  <= cfg_reload;
              os_act <= cfg_oneshot;
              cnt    <= cfg_reload;
              pend   <= 1'b0;
            end else if (pend) begin
              r_act  <= r_shd;
              os_act <= os_shd;
              cnt    <= r_shd;
              pend   <= 1'b0;
            end else begin
              cnt    <= r_act;
            end
          end else if (pend) begin
            // While idle, nothing is in progress, so promote immediately.
            r_act  <= r_shd;
            os_act <= os_shd;
            pend   <= 1'b0;
          end
        end

        RUN: begin
          if (cnt_zero) begin
            // Period boundary: promote a pending shadow, then reload with
            // the active value that is now in force.
            if (pend) begin
              r_act  <= r_shd;
              os_act <= os_shd;
              cnt    <= r_shd;
              pend   <= 1'b0;
            end else begin
              cnt    <= r_act;
            end
            // os_act still holds the mode of the period that just ended.
            if (os_act || stop) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else if (stop) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
